uart_tx_arbiter: RTL and testbench

Shares a single UART transmitter among `NUM_REQ` byte sources (the counter-driven test sender, debug printers, status reporters) using round-robin arbitration with message locking, so multi-byte messages never interleave on the serial line. It sits between the byte producers and the UART TX core, drives the TX core's start/data inputs, and tracks the core's `busy` flag to sequence one byte at a time.

---
 rtl/uart_arb_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
// State encoding, default busy timeout and grant-width helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_BUSY = 2'b01,
        WAIT_DONE = 2'b10
    } arb_state_t;

    localparam int BUSY_TIMEOUT_DEF = 16;
    localparam int CNT_W            = 8;

    function automatic int gw_of(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first set request searching upward from ptr+1.
// Purely combinational; wraps modulo NUM_REQ.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GW      = gw_of(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic               found,
    output logic [GW-1:0]      idx
);

    logic [GW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX core among NUM_REQ byte sources.
// Round-robin with message locking; one byte in flight at a time.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
    localparam int GW           = gw_of(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [GW-1:0]        grant,
    output logic                 locked,
    output logic                 tx_timeout
);

    arb_state_t state, state_d;

    logic [GW-1:0]      ptr, ptr_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               last_q, last_d;
    logic               locked_d;
    logic [GW-1:0]      grant_d;
    logic [7:0]         tx_data_d;
    logic               tx_start_d;
    logic [NUM_REQ-1:0] ready_d;
    logic               timeout_d;

    logic [NUM_REQ-1:0] own_mask;
    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [GW-1:0]      win;
    logic [7:0]         win_byte;

    logic take;
    logic at_limit;
    logic busy_to;
    logic wait_tick;
    logic byte_done;
    logic end_byte;

    // While locked only the current owner may compete.
    assign own_mask = NUM_REQ'(1) << grant;
    assign elig     = locked ? (req_valid & own_mask) : req_valid;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_picker (
        .req   (elig),
        .ptr   (ptr),
        .found (found),
        .idx   (win)
    );

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == GW'(i)) begin
                win_byte = req_data[8*i +: 8];
            end
        end
    end

    assign at_limit  = (cnt == CNT_W'(BUSY_TIMEOUT - 1));
    assign take      = (state == IDLE) && found && !tx_busy;
    assign busy_to   = (state == WAIT_BUSY) && !tx_busy && at_limit;
    assign wait_tick = (state == WAIT_BUSY) && !tx_busy && !at_limit;
    assign byte_done = (state == WAIT_DONE) && !tx_busy;
    assign end_byte  = busy_to || byte_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (take) begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (at_limit) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d      = ptr;
        cnt_d      = cnt;
        last_d     = last_q;
        locked_d   = locked;
        grant_d    = grant;
        tx_data_d  = tx_data;
        tx_start_d = 1'b0;
        ready_d    = '0;
        timeout_d  = 1'b0;

        unique case (1'b1)
            take: begin
                tx_data_d  = win_byte;
                tx_start_d = 1'b1;
                ready_d    = NUM_REQ'(1) << win;
                grant_d    = win;
                last_d     = req_last[win];
                cnt_d      = '0;
            end
            wait_tick: cnt_d = cnt + CNT_W'(1);
            busy_to:   timeout_d = 1'b1;
            default: ;
        endcase

        // A timed-out byte is treated as sent; it is never retried.
        if (end_byte) begin
            if (last_q) begin
                locked_d = 1'b0;
                ptr_d    = grant;
            end else begin
                locked_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= GW'(NUM_REQ - 1);
            cnt        <= '0;
            last_q     <= 1'b0;
            locked     <= 1'b0;
            grant      <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            req_ready  <= '0;
            tx_timeout <= 1'b0;
        end else begin
            ptr        <= ptr_d;
            cnt        <= cnt_d;
            last_q     <= last_d;
            locked     <= locked_d;
            grant      <= grant_d;
            tx_data    <= tx_data_d;
            tx_start   <= tx_start_d;
            req_ready  <= ready_d;
            tx_timeout <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a busy-flag UART model
// and a transaction-level arbiter model checked every cycle.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic [1:0]     grant;
    logic           locked;
    logic           tx_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .grant      (grant),
        .locked     (locked),
        .tx_timeout (tx_timeout)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [8:0] mem [N][8];
    int         head [N];
    int         tail [N];
    bit         hold [N];

    logic rst_ctl;
    bit   tie_low;
    int   blen;
    int   brem;

    logic         m_start;
    logic [N-1:0] m_ready;
    logic         m_timeout;
    logic [7:0]   m_data;
    int           m_grant;
    logic         m_locked;
    int           m_ptr;
    logic         m_last;
    bit           inflight;
    bit           busy_seen;
    int           waited;

    int lg_grant [16];
    int lg_data  [16];
    int lg_lock  [16];
    int lg_cyc   [16];
    int nlog;
    int to_cyc;
    int nto;

    int s1g [5] = '{0, 1, 2, 3, 0};
    int s1d [5] = '{'h10, 'h21, 'h32, 'h43, 'h11};
    int s3g [5] = '{1, 1, 1, 2, 0};
    int s3l [5] = '{0, 1, 1, 0, 0};
    int s4g [3] = '{3, 3, 0};
    int s4d [3] = '{'h71, 'h72, 'h0C};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    task automatic clear_env();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            hold[i] = 1'b0;
            for (int k = 0; k < 8; k++) mem[i][k] = '0;
        end
        nlog    = 0;
        nto     = 0;
        to_cyc  = -1;
        brem    = 0;
        blen    = 10;
        tie_low = 1'b0;
    endtask

    task automatic finish_byte();
        if (m_last) begin
            m_locked = 1'b0;
            m_ptr    = m_grant;
        end else begin
            m_locked = 1'b1;
        end
        inflight = 1'b0;
    endtask

    // Arbiter model: a byte is either free to be granted or in flight.
    task automatic model_step();
        int w;
        int j;
        if (reset) begin
            m_start   = 1'b0;
            m_ready   = '0;
            m_timeout = 1'b0;
            m_data    = '0;
            m_grant   = 0;
            m_locked  = 1'b0;
            m_ptr     = N - 1;
            m_last    = 1'b0;
            inflight  = 1'b0;
            busy_seen = 1'b0;
            waited    = 0;
        end else begin
            m_start   = 1'b0;
            m_ready   = '0;
            m_timeout = 1'b0;
            if (!inflight) begin
                if (!tx_busy) begin
                    w = -1;
                    for (int k = 1; k <= N; k++) begin
                        j = (m_ptr + k) % N;
                        if (w < 0 && req_valid[j] &&
                            (!m_locked || j == m_grant))
                            w = j;
                    end
                    if (w >= 0) begin
                        m_start    = 1'b1;
                        m_ready[w] = 1'b1;
                        m_data     = req_data[8*w +: 8];
                        m_grant    = w;
                        m_last     = req_last[w];
                        inflight   = 1'b1;
                        busy_seen  = 1'b0;
                        waited     = 0;
                    end
                end
            end else if (!busy_seen) begin
                if (tx_busy) begin
                    busy_seen = 1'b1;
                end else begin
                    waited++;
                    if (waited == TO) begin
                        m_timeout = 1'b1;
                        finish_byte();
                    end
                end
            end else if (!tx_busy) begin
                finish_byte();
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("tx_start", tx_start, m_start);
        chk("req_ready", req_ready, m_ready);
        chk("tx_timeout", tx_timeout, m_timeout);
        chk("tx_data", tx_data, m_data);
        chk("grant", grant, m_grant);
        chk("locked", locked, m_locked);
        if (tx_start === 1'b1 && nlog < 16) begin
            lg_grant[nlog] = grant;
            lg_data[nlog]  = tx_data;
            lg_lock[nlog]  = locked;
            lg_cyc[nlog]   = cyc;
            nlog++;
        end
        if (tx_timeout === 1'b1) begin
            if (nto == 0) to_cyc = cyc;
            nto++;
        end
        if (m_start) brem = blen;
        tx_busy = !tie_low && brem > 0;
        if (brem > 0) brem--;
        for (int i = 0; i < N; i++) begin
            if (m_ready[i]) head[i]++;
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i] = !hold[i] && head[i] < tail[i];
            if (head[i] < 8) begin
                req_data[8*i +: 8] = mem[i][head[i]][7:0];
                req_last[i]        = mem[i][head[i]][8];
            end
        end
        reset = rst_ctl;
        model_step();
    endtask

    task automatic run_until_log(input int n, input int budget,
                                 input string nm);
        int c;
        c = 0;
        while (nlog < n && c < budget) begin
            tick();
            c++;
        end
        checks++;
        if (nlog < n) begin
            errors++;
            $display("FAIL %s: got %0d starts expected %0d in %0d cycles",
                     nm, nlog, n, budget);
        end
    endtask

    task automatic new_scen();
        rst_ctl = 1'b1;
        tick();
        clear_env();
    endtask

    initial begin
        reset     = 1'b1;
        rst_ctl   = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        clear_env();
        model_step();

        // reset with every requester valid, then plain round robin
        push(0, 8'h10, 1'b1);
        push(0, 8'h11, 1'b1);
        push(1, 8'h21, 1'b1);
        push(2, 8'h32, 1'b1);
        push(3, 8'h43, 1'b1);
        repeat (3) tick();
        chk("rst_start", tx_start, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_locked", locked, 0);
        chk("rst_grant", grant, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_timeout", tx_timeout, 0);
        rst_ctl = 1'b0;
        run_until_log(5, 200, "s1_wait");
        for (int k = 0; k < 5; k++) begin
            chk("s1_grant", lg_grant[k], s1g[k]);
            chk("s1_data", lg_data[k], s1d[k]);
        end

        // message locking: req1 three bytes against req0/req2
        new_scen();
        push(1, 8'h51, 1'b0);
        push(1, 8'h52, 1'b0);
        push(1, 8'h53, 1'b1);
        push(0, 8'h0A, 1'b1);
        push(2, 8'h2B, 1'b1);
        hold[0] = 1'b1;
        hold[2] = 1'b1;
        repeat (2) tick();
        rst_ctl = 1'b0;
        run_until_log(1, 50, "s3_first");
        hold[0] = 1'b0;
        hold[2] = 1'b0;
        run_until_log(5, 200, "s3_wait");
        for (int k = 0; k < 5; k++) begin
            chk("s3_grant", lg_grant[k], s3g[k]);
            chk("s3_lock", lg_lock[k], s3l[k]);
        end
        repeat (15) tick();
        chk("s3_unlocked", locked, 0);

        // locked owner drops valid; req0 must wait
        new_scen();
        push(3, 8'h71, 1'b0);
        push(3, 8'h72, 1'b1);
        push(0, 8'h0C, 1'b1);
        hold[0] = 1'b1;
        repeat (2) tick();
        rst_ctl = 1'b0;
        run_until_log(1, 50, "s4_first");
        hold[3] = 1'b1;
        hold[0] = 1'b0;
        repeat (40) tick();
        chk("s4_stall_starts", nlog, 1);
        chk("s4_stall_locked", locked, 1);
        hold[3] = 1'b0;
        run_until_log(3, 200, "s4_wait");
        for (int k = 0; k < 3; k++) begin
            chk("s4_grant", lg_grant[k], s4g[k]);
            chk("s4_data", lg_data[k], s4d[k]);
        end

        // busy never rises
        new_scen();
        tie_low = 1'b1;
        push(0, 8'h81, 1'b1);
        push(1, 8'h92, 1'b1);
        repeat (2) tick();
        rst_ctl = 1'b0;
        run_until_log(2, 100, "s5_wait");
        chk("s5_to_delay", to_cyc - lg_cyc[0], 16);
        chk("s5_regrant", lg_cyc[1] - to_cyc, 1);
        chk("s5_to_count", nto, 1);
        chk("s5_grant0", lg_grant[0], 0);
        chk("s5_grant1", lg_grant[1], 1);

        // reset while locked and waiting for busy to fall
        new_scen();
        push(2, 8'hE1, 1'b0);
        push(2, 8'hE2, 1'b0);
        push(2, 8'hE3, 1'b1);
        push(0, 8'hC1, 1'b1);
        hold[0] = 1'b1;
        repeat (2) tick();
        rst_ctl = 1'b0;
        run_until_log(2, 100, "s6_wait");
        tick();
        rst_ctl = 1'b1;
        tick();
        chk("s6_pre_locked", locked, 1);
        rst_ctl = 1'b0;
        hold[0] = 1'b0;
        nlog    = 0;
        tick();
        chk("s6_post_locked", locked, 0);
        chk("s6_post_start", tx_start, 0);
        run_until_log(1, 100, "s6_regrant");
        chk("s6_first_grant", lg_grant[0], 0);
        chk("s6_first_data", lg_data[0], 'hC1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
